// File: rtl/nios_event_log_writer_if.sv
// Event stream and Avalon-MM RAM write bus used by nios_event_log_writer.
// The master modport is the writer's view; the slave modport is the view of
// the event source and the on-chip RAM.
interface nios_event_log_writer_if #(
  parameter int ADDR_W = 13
);
  logic [31:0]       ev_data;
  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  modport master (
    input  ev_data, ev_valid,
    output ev_ready,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken
  );

  modport slave (
    output ev_data, ev_valid,
    input  ev_ready,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken
  );
endinterface

// File: rtl/nios_event_log_writer.sv
// Parking event log writer: buffers 32-bit events in a small FIFO and writes
// them into a ring region of the Nios on-chip RAM, keeping pointer/status.
// A clear request zero-fills the ring one word per cycle.
// Optional macro EVLOG_SEQNUM_EN: replaces writedata[31:24] with an 8-bit
// sequence number that restarts at 0 after every clear.
module nios_event_log_writer #(
  parameter int ADDR_W     = 13,
  parameter int BASE_ADDR  = 4096,
  parameter int LOG_WORDS  = 2048,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  nios_event_log_writer_if.master bus,
  input  logic              ctl_enable,
  input  logic              ctl_wrap,
  input  logic              ctl_clear,
  output logic [ADDR_W-1:0] st_wr_ptr,
  output logic [ADDR_W:0]   st_count,
  output logic              st_full,
  output logic              st_wrapped,
  output logic              st_busy
);

  localparam int                FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(LOG_WORDS - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(LOG_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, HALT, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW:0]  fifo_wr, fifo_rd;
  logic              fifo_empty, fifo_full;
  logic              push, pop, clear_req;
  logic [31:0]       head;
  logic [ADDR_W-1:0] clr_idx;
`ifdef EVLOG_SEQNUM_EN
  logic [7:0]        seq_num;
`endif

  assign fifo_empty = (fifo_wr == fifo_rd);
  assign fifo_full  = (fifo_wr[FIFO_AW] != fifo_rd[FIFO_AW]) &&
                      (fifo_wr[FIFO_AW-1:0] == fifo_rd[FIFO_AW-1:0]);
  assign head       = fifo_mem[fifo_rd[FIFO_AW-1:0]];
  assign clear_req  = ctl_clear && (state != CLEAR);

  // Ready depends only on registered state, never on this cycle's pop.
  assign bus.ev_ready       = !fifo_full && (state != CLEAR);
  assign push               = bus.ev_valid && bus.ev_ready;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign st_full            = (st_count == FULL_COUNT);
  assign st_busy            = (state == CLEAR);

  // FIFO storage; only the pointers need a defined reset value.
  // NOTE: memory arrays are left out of reset so they map onto RAM/SRL cells;
  // the empty/full flags come from the reset pointers, so stale data is never read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr[FIFO_AW-1:0]] <= bus.ev_data;
  end

  // FIFO pointers; a clear request flushes everything buffered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr <= '0;
      fifo_rd <= '0;
    end else if (clear_req) begin
      fifo_wr <= '0;
      fifo_rd <= '0;
    end else begin
      if (push) fifo_wr <= fifo_wr + (FIFO_AW+1)'(1);
      if (pop)  fifo_rd <= fifo_rd + (FIFO_AW+1)'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and pop decision: clear beats disable, disable beats full/wrap.
  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (clear_req) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        IDLE: if (ctl_enable) state_nxt = RUN;
        RUN: begin
          if (!ctl_enable)             state_nxt = IDLE;
          else if (st_full && !ctl_wrap) state_nxt = HALT;
          else                         pop = !fifo_empty;
        end
        HALT: begin
          if (!ctl_enable)   state_nxt = IDLE;
          else if (ctl_wrap) state_nxt = RUN;
        end
        CLEAR: if (clr_idx == LAST_IDX) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // RAM write port and ring status: one registered write per pop or sweep step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_write      <= 1'b0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_writedata  <= '0;
      st_wr_ptr          <= '0;
      st_count           <= '0;
      st_wrapped         <= 1'b0;
      clr_idx            <= '0;
`ifdef EVLOG_SEQNUM_EN
      seq_num            <= '0;
`endif
    end else begin
      bus.mem_write      <= 1'b0;
      bus.mem_chipselect <= 1'b0;
      if (pop) begin
        bus.mem_write      <= 1'b1;
        bus.mem_chipselect <= 1'b1;
        bus.mem_address    <= BASE + st_wr_ptr;
`ifdef EVLOG_SEQNUM_EN
        bus.mem_writedata  <= {seq_num, head[23:0]};
        seq_num            <= seq_num + 8'd1;
`else
        bus.mem_writedata  <= head;
`endif
        st_wr_ptr <= (st_wr_ptr == LAST_IDX) ? '0 : st_wr_ptr + ADDR_W'(1);
        if (st_full) st_wrapped <= 1'b1;
        else         st_count   <= st_count + (ADDR_W+1)'(1);
      end else if (state == CLEAR) begin
        bus.mem_write      <= 1'b1;
        bus.mem_chipselect <= 1'b1;
        bus.mem_address    <= BASE + clr_idx;
        bus.mem_writedata  <= '0;
        if (clr_idx == LAST_IDX) begin
          clr_idx    <= '0;
          st_wr_ptr  <= '0;
          st_count   <= '0;
          st_wrapped <= 1'b0;
`ifdef EVLOG_SEQNUM_EN
          seq_num    <= '0;
`endif
        end else begin
          clr_idx <= clr_idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule
